mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + memory stage), the shared memory port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface mem_arbiter_if #(parameter int DATA_W = 32);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic              dm_word;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              flush;

    logic              mem_req;
    logic              mem_we;
    logic              mem_word;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_word, dm_addr, dm_wdata, flush,
               mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_req, mem_we, mem_word, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_word, dm_addr, dm_wdata, flush,
               mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_req, mem_we, mem_word, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data-memory accesses onto one shared memory port.
// Data accesses win ties; an issued memory transaction always runs to ack or timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int DATA_W  = 32
) (
    input logic          clock,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP_IF = 3'd3,
        RESP_DM = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic              load_if;
    logic              load_dm;
    logic              busy;
    logic              timeout;
    logic              if_ready;
    logic              dm_ready;

    logic              mem_req;
    logic              mem_we;
    logic              mem_word;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic [CNT_W-1:0]  count;
    logic              drop;
    logic              err;

    assign busy    = (state == BUSY_IF) || (state == BUSY_DM);
    assign timeout = busy && !bus.mem_ack && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_if    = 1'b0;
        load_dm    = 1'b0;
        if_ready   = 1'b0;
        dm_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dm_req) begin
                    state_next = BUSY_DM;
                    load_dm    = 1'b1;
                end else if (bus.if_req) begin
                    state_next = BUSY_IF;
                    load_if    = 1'b1;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack || timeout) begin
                    state_next = RESP_IF;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ack || timeout) begin
                    state_next = RESP_DM;
                end
            end
            RESP_IF: begin
                // A flush arriving in the response cycle itself must also suppress the pulse.
                if_ready   = !drop && !bus.flush;
                state_next = IDLE;
            end
            RESP_DM: begin
                dm_ready   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_word  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            count     <= '0;
            drop      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (load_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= bus.dm_we;
                mem_word  <= bus.dm_word;
                mem_addr  <= bus.dm_addr;
                mem_wdata <= bus.dm_wdata;
                count     <= '0;
            end else if (load_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_word  <= 1'b1;
                mem_addr  <= bus.if_addr;
                mem_wdata <= '0;
                count     <= '0;
            end else if (busy) begin
                if (bus.mem_ack) begin
                    mem_req <= 1'b0;
                    count   <= '0;
                    if (state == BUSY_IF) begin
                        if_rdata <= bus.mem_rdata;
                    end else begin
                        dm_rdata <= bus.mem_rdata;
                    end
                end else if (timeout) begin
                    mem_req <= 1'b0;
                    count   <= '0;
                    err     <= 1'b1;
                    if (state == BUSY_IF) begin
                        if_rdata <= '0;
                    end else begin
                        dm_rdata <= '0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end

            // The flushed fetch still finishes on memory; only its result is hidden.
            if (state_next == IDLE && state != IDLE) begin
                drop <= 1'b0;
            end else if (bus.flush && (state == BUSY_IF || state == RESP_IF)) begin
                drop <= 1'b1;
            end
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_word  = mem_word;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rdata  = if_rdata;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.if_ready  = if_ready;
    assign bus.dm_ready  = dm_ready;
    assign bus.err       = err;
    assign bus.stall_if  = bus.if_req && !if_ready;
    assign bus.stall_mem = bus.dm_req && !dm_ready;

    a_ready_exclusive: assert property (@(posedge clock) disable iff (!rst)
        !(if_ready && dm_ready));
    a_req_only_busy: assert property (@(posedge clock) disable iff (!rst)
        mem_req |-> busy);

endmodule
